// File: rtl/guess_engine.sv
// Number-guessing game core: digit entry, guess compare, hints, guess budget, rounds, countdown.
// Latency: confirm in PLAY -> CHECK next cycle; hint/guesses_left/round/next state one cycle later.
// Backpressure: none; all inputs are single-cycle pulses, and any pulse the current state does not use is dropped.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   tick_1hz     one-cycle pulse per second (used only when GUESS_TIMER_EN is defined)
//   digit_up     per-digit increment pulses, bit 0 = least significant digit
//   confirm      confirm pulse (start game / submit guess / next round / restart)
//   target       BCD target, held stable from the cycle after target_req
//   target_req   one-cycle request for a new target
//   guess        current BCD guess
//   hint         compare result: none, guess low, guess high or equal
//   guesses_left remaining wrong guesses this round
//   round        rounds completed
//   timer        seconds remaining in the round
//   game_state   000 IDLE, 001 PLAY, 010 CHECK, 011 ROUND_WON, 100 GAME_WON, 101 GAME_LOST
//
// Build option: define GUESS_TIMER_EN to compile in the countdown timer and the
// timeout loss. Without it, timer is the constant TIME_LIMIT and tick_1hz is unused.

module guess_engine #(
  parameter int DIGITS      = 3,
  parameter int MAX_GUESSES = 5,
  parameter int ROUNDS      = 3,
  parameter int TIME_LIMIT  = 99
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic [DIGITS-1:0]     digit_up,
  input  logic                  confirm,
  input  logic [4*DIGITS-1:0]   target,
  output logic                  target_req,
  output logic [4*DIGITS-1:0]   guess,
  output logic [1:0]            hint,
  output logic [2:0]            guesses_left,
  output logic [2:0]            round,
  output logic [6:0]            timer,
  output logic [2:0]            game_state
);

  localparam logic [2:0] MAX_G    = 3'(MAX_GUESSES);
  localparam logic [2:0] ROUNDS_L = 3'(ROUNDS);
  localparam logic [6:0] TL       = 7'(TIME_LIMIT);

  localparam logic [1:0] HINT_NONE  = 2'b00;
  localparam logic [1:0] HINT_LOW   = 2'b01;
  localparam logic [1:0] HINT_HIGH  = 2'b10;
  localparam logic [1:0] HINT_EQUAL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_CHECK     = 3'd2,
    S_ROUND_WON = 3'd3,
    S_GAME_WON  = 3'd4,
    S_GAME_LOST = 3'd5
  } state_t;

  state_t state;

  assign game_state = state;

  // ---------------------------------------------------------------------------
  // Guess digit increment: every requested digit steps 0..9 and wraps.
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] guess_inc;

  always_comb begin
    guess_inc = guess;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_up[i]) begin
        guess_inc[4*i +: 4] = (guess[4*i +: 4] == 4'd9) ? 4'd0 : guess[4*i +: 4] + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BCD magnitude compare, most significant digit first. The first digit that
  // differs decides; if none differs the values are equal.
  // ---------------------------------------------------------------------------
  logic [1:0] cmp_result;

  always_comb begin
    cmp_result = HINT_EQUAL;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (cmp_result == HINT_EQUAL) begin
        if (guess[4*i +: 4] < target[4*i +: 4]) begin
          cmp_result = HINT_LOW;
        end else if (guess[4*i +: 4] > target[4*i +: 4]) begin
          cmp_result = HINT_HIGH;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Countdown timer (optional). Reloaded whenever a round (re)starts or the
  // game returns to IDLE; counts down only in PLAY on a tick that does not
  // coincide with confirm, and sticks at zero.
  // ---------------------------------------------------------------------------
  logic timed_out;

`ifdef GUESS_TIMER_EN
  logic [6:0] timer_q;
  logic       timer_reload;
  logic       timer_dec;

  assign timer_reload = confirm && (state == S_IDLE || state == S_ROUND_WON ||
                                    state == S_GAME_WON || state == S_GAME_LOST);
  assign timer_dec    = (state == S_PLAY) && tick_1hz && !confirm && (timer_q != 7'd0);
  assign timed_out    = (timer_q == 7'd0);
  assign timer        = timer_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= TL;
    end else if (timer_reload) begin
      timer_q <= TL;
    end else if (timer_dec) begin
      timer_q <= timer_q - 7'd1;
    end
  end
`else
  logic unused_tick;

  assign unused_tick = tick_1hz;
  assign timed_out   = 1'b0;
  assign timer       = TL;
`endif

  // ---------------------------------------------------------------------------
  // Game FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      guess        <= '0;
      hint         <= HINT_NONE;
      guesses_left <= MAX_G;
      round        <= 3'd0;
      target_req   <= 1'b0;
    end else begin
      target_req <= 1'b0;

      case (state)
        S_IDLE: begin
          if (confirm) begin
            state        <= S_PLAY;
            target_req   <= 1'b1;
            guesses_left <= MAX_G;
            guess        <= '0;
            hint         <= HINT_NONE;
          end
        end

        S_PLAY: begin
          // An expired timer ends the round before any entry in that cycle
          // is considered, including a late confirm.
          if (timed_out) begin
            state <= S_GAME_LOST;
          end else if (confirm) begin
            // Digit presses coinciding with confirm are dropped so the
            // submitted guess is exactly what the player saw.
            state <= S_CHECK;
          end else begin
            guess <= guess_inc;
          end
        end

        S_CHECK: begin
          hint <= cmp_result;
          if (cmp_result == HINT_EQUAL) begin
            round <= round + 3'd1;
            state <= (round + 3'd1 == ROUNDS_L) ? S_GAME_WON : S_ROUND_WON;
          end else begin
            // guesses_left is at least 1 here: PLAY is only entered with a
            // non-zero budget and the last wrong guess leaves to GAME_LOST.
            guesses_left <= guesses_left - 3'd1;
            state        <= (guesses_left == 3'd1) ? S_GAME_LOST : S_PLAY;
          end
        end

        S_ROUND_WON: begin
          // The hint keeps showing the winning result until the next check.
          if (confirm) begin
            state        <= S_PLAY;
            target_req   <= 1'b1;
            guesses_left <= MAX_G;
            guess        <= '0;
          end
        end

        S_GAME_WON, S_GAME_LOST: begin
          if (confirm) begin
            state        <= S_IDLE;
            guess        <= '0;
            hint         <= HINT_NONE;
            guesses_left <= MAX_G;
            round        <= 3'd0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guess_engine.sv
// Self-checking bench for guess_engine: directed game scenarios with literal
// expectations, then randomized play, all checked every cycle against a
// game-level model (guess held as decimal digits, target as an integer).

module tb_guess_engine;

  localparam int D  = 3;
  localparam int MG = 5;
  localparam int R  = 3;
  localparam int TL = 99;

`ifdef GUESS_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_CHECK = 2, ST_RWON = 3, ST_GWON = 4, ST_LOST = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            tick_1hz;
  logic [D-1:0]    digit_up;
  logic            confirm;
  logic [4*D-1:0]  target;
  logic            target_req;
  logic [4*D-1:0]  guess;
  logic [1:0]      dut_hint;
  logic [2:0]      guesses_left;
  logic [2:0]      round;
  logic [6:0]      timer;
  logic [2:0]      game_state;

  guess_engine #(.DIGITS(D), .MAX_GUESSES(MG), .ROUNDS(R), .TIME_LIMIT(TL)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .digit_up(digit_up), .confirm(confirm),
    .target(target), .target_req(target_req), .guess(guess), .hint(dut_hint),
    .guesses_left(guesses_left), .round(round), .timer(timer), .game_state(game_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // ---------------- behavioural model ----------------
  int m_state, m_hint, m_left, m_round, m_timer, m_req;
  int m_dig[D];
  int tgt = 0;            // current target as a decimal number
  int forced_target = -1; // >= 0: the generator hands out this value

  function automatic int pow10(input int e);
    int p = 1;
    for (int k = 0; k < e; k++) p = p * 10;
    return p;
  endfunction

  function automatic int guess_value();
    int v = 0;
    for (int k = 0; k < D; k++) v = v + m_dig[k] * pow10(k);
    return v;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] b = '0;
    for (int k = 0; k < D; k++) b[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return b;
  endfunction

  function automatic void model_reset();
    m_state = ST_IDLE; m_hint = 0; m_left = MG; m_round = 0; m_timer = TL; m_req = 0;
    for (int k = 0; k < D; k++) m_dig[k] = 0;
  endfunction

  function automatic void new_round();
    m_req = 1; m_left = MG; m_timer = TL;
    for (int k = 0; k < D; k++) m_dig[k] = 0;
    tgt = (forced_target >= 0) ? forced_target : $urandom_range(0, pow10(D) - 1);
  endfunction

  function automatic void model_step(input logic [D-1:0] up, input logic c, input logic t);
    int g;
    m_req = 0;
    case (m_state)
      ST_IDLE: if (c) begin m_state = ST_PLAY; m_hint = 0; new_round(); end
      ST_PLAY: begin
        if (TIMER_EN && m_timer == 0) m_state = ST_LOST;
        else if (c) m_state = ST_CHECK;
        else begin
          for (int k = 0; k < D; k++) if (up[k]) m_dig[k] = (m_dig[k] + 1) % 10;
          if (TIMER_EN && t && m_timer > 0) m_timer = m_timer - 1;
        end
      end
      ST_CHECK: begin
        g = guess_value();
        if (g == tgt) begin
          m_hint = 3; m_round = m_round + 1;
          m_state = (m_round == R) ? ST_GWON : ST_RWON;
        end else begin
          m_hint = (g < tgt) ? 1 : 2; m_left = m_left - 1;
          m_state = (m_left == 0) ? ST_LOST : ST_PLAY;
        end
      end
      ST_RWON: if (c) begin m_state = ST_PLAY; new_round(); end
      default: if (c) model_reset();
    endcase
  endfunction

  // ---------------- checking ----------------
  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("game_state",   int'(game_state),   m_state);
      chk("guess",        int'(guess),        int'(to_bcd(guess_value())));
      chk("hint",         int'(dut_hint),     m_hint);
      chk("guesses_left", int'(guesses_left), m_left);
      chk("round",        int'(round),        m_round);
      chk("timer",        int'(timer),        m_timer);
      chk("target_req",   int'(target_req),   m_req);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [D-1:0] up, input logic c, input logic t);
    digit_up = up; confirm = c; tick_1hz = t;
    @(posedge clk);
    model_step(up, c, t);
    #1;
    digit_up = '0; confirm = 1'b0; tick_1hz = 1'b0;
    if (m_req != 0) target = to_bcd(tgt);
  endtask

  task automatic set_guess(input int value);
    int n;
    for (int k = 0; k < D; k++) begin
      n = (((value / pow10(k)) % 10) - m_dig[k] + 10) % 10;
      repeat (n) step(D'(1 << k), 1'b0, 1'b0);
    end
  endtask

  task automatic submit();
    step('0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0; tick_1hz = 1'b0; digit_up = '0; confirm = 1'b0; target = '0;
    model_reset();
    #12;
    chk("rst_state", int'(game_state), 0);
    chk("rst_guess", int'(guess), 0);
    chk("rst_hint", int'(dut_hint), 0);
    chk("rst_left", int'(guesses_left), 5);
    chk("rst_round", int'(round), 0);
    chk("rst_timer", int'(timer), 99);
    chk("rst_req", int'(target_req), 0);
    @(negedge clk); #2;
    rst = 1'b1;
    check_en = 1'b1;

    // Start: one target_req pulse, fresh round values.
    forced_target = 472;
    step('0, 1'b1, 1'b0);
    chk("start_req", int'(target_req), 1);
    chk("start_state", int'(game_state), 1);
    chk("start_left", int'(guesses_left), 5);
    chk("start_timer", int'(timer), 99);
    chk("start_guess", int'(guess), 0);
    step('0, 1'b0, 1'b0);
    chk("req_once", int'(target_req), 0);

    // 300 < 472 -> low; 500 > 472 -> high.
    set_guess(300);
    step('0, 1'b1, 1'b0);
    chk("check_state", int'(game_state), 2);
    step('0, 1'b0, 1'b0);
    chk("low_hint", int'(dut_hint), 1);
    chk("low_left", int'(guesses_left), 4);
    set_guess(500);
    submit();
    chk("high_hint", int'(dut_hint), 2);
    chk("high_left", int'(guesses_left), 3);

    // Eleven presses of digit 0 wrap 0 -> 1.
    repeat (11) step(3'b001, 1'b0, 1'b0);
    chk("wrap_guess", int'(guess), 'h501);
    // Digit press together with confirm is dropped.
    step(3'b111, 1'b1, 1'b0);
    chk("ign_guess", int'(guess), 'h501);
    chk("ign_state", int'(game_state), 2);
    step('0, 1'b0, 1'b0);
    chk("left_2", int'(guesses_left), 2);

    // Run out of guesses.
    submit();
    submit();
    chk("lost_left", int'(guesses_left), 0);
    chk("lost_state", int'(game_state), 5);
    step(3'b111, 1'b0, 1'b1);
    chk("frozen_guess", int'(guess), 'h501);
    step('0, 1'b1, 1'b0);
    chk("restart_state", int'(game_state), 0);
    chk("restart_round", int'(round), 0);

    // Three winning rounds.
    step('0, 1'b1, 1'b0);
    set_guess(472);
    submit();
    chk("r1_round", int'(round), 1);
    chk("r1_hint", int'(dut_hint), 3);
    step('0, 1'b1, 1'b0);
    set_guess(472);
    submit();
    chk("r2_state", int'(game_state), 3);
    chk("r2_round", int'(round), 2);
    step('0, 1'b1, 1'b0);
    chk("r2_req", int'(target_req), 1);
    set_guess(472);
    submit();
    chk("win_state", int'(game_state), 4);
    chk("win_round", int'(round), 3);
    step('0, 1'b1, 1'b0);
    chk("win_idle", int'(game_state), 0);

    // Timer: tick coinciding with confirm does not count.
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b1);
    chk("tick_conf_timer", int'(timer), 99);
    step('0, 1'b0, 1'b0);
`ifdef GUESS_TIMER_EN
    repeat (99) step('0, 1'b0, 1'b1);
    chk("timeout_timer", int'(timer), 0);
    chk("timeout_still_play", int'(game_state), 1);
    step('0, 1'b0, 1'b0);
    chk("timeout_state", int'(game_state), 5);
    step('0, 1'b1, 1'b0);
`else
    repeat (200) step('0, 1'b0, 1'b1);
    chk("notimer_timer", int'(timer), 99);
    chk("notimer_state", int'(game_state), 1);
`endif

    // Asynchronous reset mid-round.
    forced_target = -1;
    if (m_state == ST_IDLE) step('0, 1'b1, 1'b0);
    step(3'b011, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_state", int'(game_state), 0);
    chk("arst_guess", int'(guess), 0);
    chk("arst_left", int'(guesses_left), 5);
    @(negedge clk); #2;
    rst = 1'b1;

    // Randomized play.
    for (int it = 0; it < 300; it++) begin
      repeat ($urandom_range(0, 4))
        step(($urandom_range(0, 1) != 0) ? D'($urandom_range(0, 7)) : '0,
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) != 0) set_guess(tgt);
      submit();
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
